tx_control: RTL and testbench
=============================

Name: tx_control

Overview:
- Transmit-side sequencer for the low-power communication system.
- Collects responses from the register file (8-bit read data) and the ALU (16-bit result).
- Buffers one pending response per source and arbitrates between them.
- Serializes each response into bytes over a valid/ready handshake to the UART transmit path.
- Drives a Busy flag used for upstream clock gating.

Parameters:
width, 8, byte width of register-file data and of each transmitted frame byte; ALU result is 2*width.

Ports:
CLK  input  1  system clock, all logic on rising edge
Reset  input  1  synchronous, active-high reset
RdData  input  width  register-file read data
RdData_Valid  input  1  one-cycle strobe, RdData valid
ALU_OUT  input  2*width  ALU result
ALU_OUT_Valid  input  1  one-cycle strobe, ALU_OUT valid
Tx_Ready  input  1  transmit path can accept a byte
Tx_P_Data  output  width  byte to transmit
Tx_Valid  output  1  Tx_P_Data valid; transfer occurs when Tx_Valid and Tx_Ready are both high
Busy  output  1  high while any response is pending or in flight
Overrun  output  1  one-cycle pulse: a response was dropped

Behaviour:
- Reset (synchronous, active-high, sampled on rising CLK):
  - state=IDLE; both pending flags cleared; all outputs 0.
  - Reset mid-transfer discards all buffered and in-flight data; no partial completion.
- Source buffers:
  - RdData_Valid with rd_pend=0: RdData is captured and rd_pend set.
  - ALU_OUT_Valid with alu_pend=0: ALU_OUT is captured and alu_pend set.
  - A pending flag clears on the handshake of that source's final byte.
  - A new strobe in that same cycle is accepted: the flag stays set and the new data is captured, with no overrun.
  - A strobe while the flag is set and not clearing drops the new data and pulses Overrun for 1 cycle, registered on the next edge.
- FSM states: IDLE, SEND_RD, SEND_ALU_LO, SEND_ALU_HI (plus SEND_TAG, see Optional Feature).
  - IDLE: if rd_pend, go to SEND_RD; else if alu_pend, go to SEND_ALU_LO. Read data has fixed priority.
  - SEND_RD: Tx_P_Data = rd buffer. On handshake, clear rd_pend. Then go to SEND_ALU_LO if alu_pend, else IDLE.
  - SEND_ALU_LO: Tx_P_Data = ALU[width-1:0]. On handshake, go to SEND_ALU_HI.
  - SEND_ALU_HI: Tx_P_Data = ALU[2*width-1:width]. On handshake, clear alu_pend. Then go to SEND_RD if rd_pend, else IDLE.
  - No state advances without a handshake. Tx_Ready low holds the state and the output stable indefinitely.
- Outputs:
  - Tx_Valid = (state != IDLE); Moore output, registered.
  - Tx_P_Data is registered, stable while Tx_Valid is high, and 0 in IDLE.
  - Busy = rd_pend | alu_pend | (state != IDLE).
- Latency:
  - Strobe sampled at edge E0 sets pend; FSM leaves IDLE at E1; Tx_Valid is high after E1.
  - Total: 2 edges from strobe to first byte offered.
  - Back-to-back with Tx_Ready held high: one byte per cycle, no idle bubble between chained responses.
- Tx_Ready while Tx_Valid is low is ignored.

Optional Feature:
- Macro TX_FRAME_TAG_EN.
- When defined:
  - Every response is preceded by a tag byte from state SEND_TAG: 0x5A for register data, 0xA5 for ALU results.
  - IDLE goes to SEND_TAG, which selects the source by the same priority.
  - The tag handshake advances to SEND_RD or SEND_ALU_LO.
  - Chaining from SEND_RD or SEND_ALU_HI also passes through SEND_TAG.
- When undefined: SEND_TAG and the tag constants are absent; behaviour is exactly as above.

Decomposition:
- Package tx_ctrl_pkg: state encoding, TAG_RD=8'h5A, TAG_ALU=8'hA5.
- Sub-module tx_src_buffer (parameter DW):
  - Implements the capture register, pending flag, clear-on-consume with same-cycle re-capture, and Overrun detection.
  - Instantiated twice: DW=width and DW=2*width.
- Overrun = OR of both instances.

Test Plan:
1. RdData=0x3C strobe, Tx_Ready=1 -> Tx_Valid high 1 cycle 2 edges later with Tx_P_Data=0x3C; Busy drops the next cycle.
2. ALU_OUT=0x1234 strobe, Tx_Ready=1 -> bytes 0x34 then 0x12 on consecutive cycles.
3. ALU_OUT=0x1234, Tx_Ready=0 for 5 cycles then 1 -> Tx_Valid high with 0x34 held all 5 cycles; 0x12 follows after the handshake.
4. RdData=0x55 and ALU_OUT=0xBEEF in the same cycle -> sequence 0x55, 0xEF, 0xBE with no gaps (with TX_FRAME_TAG_EN: 0x5A, 0x55, 0xA5, 0xEF, 0xBE).
5. RdData=0x55, Tx_Ready=0, then RdData=0x77 strobe -> Overrun pulses once; only 0x55 is transmitted. A strobe of 0x66 in the cycle 0x55 handshakes is accepted and sent next.
6. Reset asserted while in SEND_ALU_HI with rd_pend set -> next cycle: Tx_Valid=0, Busy=0, Tx_P_Data=0; no further bytes emitted.

Source files
------------

// File: rtl/tx_ctrl_pkg.sv
// Shared state encoding and frame tag constants for the transmit sequencer.
// Optional feature macro: TX_FRAME_TAG_EN adds the SEND_TAG state and tag bytes.
package tx_ctrl_pkg;

    localparam int unsigned STATE_W = 3;

    localparam logic [STATE_W-1:0] ST_IDLE        = 3'd0;
    localparam logic [STATE_W-1:0] ST_SEND_RD     = 3'd1;
    localparam logic [STATE_W-1:0] ST_SEND_ALU_LO = 3'd2;
    localparam logic [STATE_W-1:0] ST_SEND_ALU_HI = 3'd3;

`ifdef TX_FRAME_TAG_EN
    localparam logic [STATE_W-1:0] ST_SEND_TAG    = 3'd4;

    localparam logic [7:0] TAG_RD  = 8'h5A;
    localparam logic [7:0] TAG_ALU = 8'hA5;
`endif

endpackage

// File: rtl/tx_src_buffer.sv
// Single-entry response buffer: capture register, pending flag and overrun pulse.
// A strobe coinciding with the consume of the pending entry re-captures without overrun.
module tx_src_buffer
    import tx_ctrl_pkg::*;
#(
    parameter int unsigned DW = 8
) (
    input  logic          CLK,
    input  logic          Reset,
    input  logic [DW-1:0] in_data,
    input  logic          in_valid,
    input  logic          consume,
    output logic [DW-1:0] buf_data,
    output logic          pend,
    output logic          overrun
);

    logic [DW-1:0] data_q, data_d;
    logic          pend_q, pend_d;
    logic          ovr_q, ovr_d;

    always_comb begin
        data_d = data_q;
        pend_d = pend_q;
        ovr_d  = 1'b0;
        if (consume) begin
            pend_d = 1'b0;
        end
        if (in_valid) begin
            if (!pend_q || consume) begin
                data_d = in_data;
                pend_d = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            data_q <= '0;
            pend_q <= 1'b0;
            ovr_q  <= 1'b0;
        end else begin
            data_q <= data_d;
            pend_q <= pend_d;
            ovr_q  <= ovr_d;
        end
    end

    assign buf_data = data_q;
    assign pend     = pend_q;
    assign overrun  = ovr_q;

endmodule

// File: rtl/tx_control.sv
// Transmit sequencer: buffers register-file and ALU responses and serialises them as bytes.
// Optional feature macro: TX_FRAME_TAG_EN prefixes each response with a source tag byte.
module tx_control
    import tx_ctrl_pkg::*;
#(
    parameter int unsigned width = 8
) (
    input  logic               CLK,
    input  logic               Reset,
    input  logic [width-1:0]   RdData,
    input  logic               RdData_Valid,
    input  logic [2*width-1:0] ALU_OUT,
    input  logic               ALU_OUT_Valid,
    input  logic               Tx_Ready,
    output logic [width-1:0]   Tx_P_Data,
    output logic               Tx_Valid,
    output logic               Busy,
    output logic               Overrun
);

    logic [STATE_W-1:0] state_q, state_d;
    logic [width-1:0]   tx_data_q, tx_data_d;

    logic [width-1:0]   rd_buf;
    logic [2*width-1:0] alu_buf;
    logic               rd_pend, alu_pend;
    logic               rd_ovr, alu_ovr;
    logic               handshake, rd_consume, alu_consume;

`ifdef TX_FRAME_TAG_EN
    // Source selected for the tag currently offered: 0 = register data, 1 = ALU.
    logic sel_q, sel_d;
`endif

    assign handshake   = Tx_Valid && Tx_Ready;
    assign rd_consume  = handshake && (state_q == ST_SEND_RD);
    assign alu_consume = handshake && (state_q == ST_SEND_ALU_HI);

    tx_src_buffer #(
        .DW(width)
    ) u_rd_buf (
        .CLK      (CLK),
        .Reset    (Reset),
        .in_data  (RdData),
        .in_valid (RdData_Valid),
        .consume  (rd_consume),
        .buf_data (rd_buf),
        .pend     (rd_pend),
        .overrun  (rd_ovr)
    );

    tx_src_buffer #(
        .DW(2 * width)
    ) u_alu_buf (
        .CLK      (CLK),
        .Reset    (Reset),
        .in_data  (ALU_OUT),
        .in_valid (ALU_OUT_Valid),
        .consume  (alu_consume),
        .buf_data (alu_buf),
        .pend     (alu_pend),
        .overrun  (alu_ovr)
    );

    always_comb begin
        state_d = state_q;
`ifdef TX_FRAME_TAG_EN
        sel_d   = sel_q;
`endif
        case (state_q)
            ST_IDLE: begin
`ifdef TX_FRAME_TAG_EN
                if (rd_pend) begin
                    state_d = ST_SEND_TAG;
                    sel_d   = 1'b0;
                end else if (alu_pend) begin
                    state_d = ST_SEND_TAG;
                    sel_d   = 1'b1;
                end
`else
                if (rd_pend) begin
                    state_d = ST_SEND_RD;
                end else if (alu_pend) begin
                    state_d = ST_SEND_ALU_LO;
                end
`endif
            end
`ifdef TX_FRAME_TAG_EN
            ST_SEND_TAG: begin
                if (handshake) begin
                    state_d = sel_q ? ST_SEND_ALU_LO : ST_SEND_RD;
                end
            end
`endif
            ST_SEND_RD: begin
                if (handshake) begin
                    if (alu_pend) begin
`ifdef TX_FRAME_TAG_EN
                        state_d = ST_SEND_TAG;
                        sel_d   = 1'b1;
`else
                        state_d = ST_SEND_ALU_LO;
`endif
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_SEND_ALU_LO: begin
                if (handshake) begin
                    state_d = ST_SEND_ALU_HI;
                end
            end
            ST_SEND_ALU_HI: begin
                if (handshake) begin
                    if (rd_pend) begin
`ifdef TX_FRAME_TAG_EN
                        state_d = ST_SEND_TAG;
                        sel_d   = 1'b0;
`else
                        state_d = ST_SEND_RD;
`endif
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output byte follows the next state; the selected buffer cannot change while it is offered.
    always_comb begin
        tx_data_d = '0;
        case (state_d)
            ST_SEND_RD:     tx_data_d = rd_buf;
            ST_SEND_ALU_LO: tx_data_d = alu_buf[width-1:0];
            ST_SEND_ALU_HI: tx_data_d = alu_buf[2*width-1:width];
`ifdef TX_FRAME_TAG_EN
            ST_SEND_TAG:    tx_data_d = sel_d ? width'(TAG_ALU) : width'(TAG_RD);
`endif
            default:        tx_data_d = '0;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_q   <= ST_IDLE;
            tx_data_q <= '0;
`ifdef TX_FRAME_TAG_EN
            sel_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            tx_data_q <= tx_data_d;
`ifdef TX_FRAME_TAG_EN
            sel_q     <= sel_d;
`endif
        end
    end

    assign Tx_Valid  = (state_q != ST_IDLE);
    assign Tx_P_Data = tx_data_q;
    assign Busy      = rd_pend | alu_pend | (state_q != ST_IDLE);
    assign Overrun   = rd_ovr | alu_ovr;

endmodule

// File: tb/tb_tx_control.sv
// Scoreboard bench for tx_control: directed stimulus pushes expected bytes, a monitor checks them.
// Honours TX_FRAME_TAG_EN by expecting tag bytes before each response.
module tb_tx_control;

    localparam int W = 8;

`ifdef TX_FRAME_TAG_EN
    localparam int TAGS = 1;
`else
    localparam int TAGS = 0;
`endif

    logic           CLK = 1'b0;
    logic           Reset;
    logic [W-1:0]   RdData;
    logic           RdData_Valid;
    logic [2*W-1:0] ALU_OUT;
    logic           ALU_OUT_Valid;
    logic           Tx_Ready;
    logic [W-1:0]   Tx_P_Data;
    logic           Tx_Valid;
    logic           Busy;
    logic           Overrun;

    always #5 CLK = ~CLK;

    tx_control #(
        .width(W)
    ) dut (
        .CLK           (CLK),
        .Reset         (Reset),
        .RdData        (RdData),
        .RdData_Valid  (RdData_Valid),
        .ALU_OUT       (ALU_OUT),
        .ALU_OUT_Valid (ALU_OUT_Valid),
        .Tx_Ready      (Tx_Ready),
        .Tx_P_Data     (Tx_P_Data),
        .Tx_Valid      (Tx_Valid),
        .Busy          (Busy),
        .Overrun       (Overrun)
    );

    logic [7:0] exp_q[$];
    int         n_tests = 0;
    int         n_fail  = 0;
    int         ovr_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic push_rd(input logic [7:0] d);
        if (TAGS != 0) exp_q.push_back(8'h5A);
        exp_q.push_back(d);
    endtask

    task automatic push_alu(input logic [15:0] d);
        if (TAGS != 0) exp_q.push_back(8'hA5);
        exp_q.push_back(d[7:0]);
        exp_q.push_back(d[15:8]);
    endtask

    task automatic drain(input string name, input int exp_cycles);
        int c;
        c = 0;
        while (Busy && c < 50) begin
            tick();
            c++;
        end
        check({name, "_cycles"}, c, exp_cycles);
        check({name, "_queue_empty"}, exp_q.size(), 0);
    endtask

    // Monitor: sampled on the falling edge, away from DUT updates and stimulus changes.
    initial begin
        logic       prev_stall;
        logic [7:0] prev_data;
        logic [7:0] e;
        prev_stall = 1'b0;
        prev_data  = '0;
        forever begin
            @(negedge CLK);
            if (Reset) begin
                prev_stall = 1'b0;
            end else begin
                if (Overrun) ovr_cnt++;
                if (prev_stall && Tx_Valid) check("stall_hold", Tx_P_Data, prev_data);
                if (Tx_Valid && Tx_Ready) begin
                    if (exp_q.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL unexpected_byte: got 0x%0h, expected no byte", Tx_P_Data);
                    end else begin
                        e = exp_q.pop_front();
                        check("tx_byte", Tx_P_Data, e);
                    end
                end
                prev_stall = Tx_Valid && !Tx_Ready;
                prev_data  = Tx_P_Data;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        Reset         = 1'b1;
        RdData        = '0;
        RdData_Valid  = 1'b0;
        ALU_OUT       = '0;
        ALU_OUT_Valid = 1'b0;
        Tx_Ready      = 1'b0;
        repeat (2) tick();
        check("rst_valid", Tx_Valid, 0);
        check("rst_busy", Busy, 0);
        check("rst_data", Tx_P_Data, 0);
        check("rst_overrun", Overrun, 0);
        Reset = 1'b0;
        tick();

        // 1: single register read, latency of two edges.
        Tx_Ready     = 1'b1;
        RdData       = 8'h3C;
        RdData_Valid = 1'b1;
        push_rd(8'h3C);
        tick();
        RdData_Valid = 1'b0;
        check("t1_busy_e0", Busy, 1);
        check("t1_valid_e0", Tx_Valid, 0);
        tick();
        check("t1_valid_e1", Tx_Valid, 1);
        check("t1_data_e1", Tx_P_Data, (TAGS != 0) ? 8'h5A : 8'h3C);
        drain("t1", 1 + TAGS);
        check("t1_idle_data", Tx_P_Data, 0);

        // 2: ALU result, low byte then high byte back to back.
        ALU_OUT       = 16'h1234;
        ALU_OUT_Valid = 1'b1;
        push_alu(16'h1234);
        tick();
        ALU_OUT_Valid = 1'b0;
        drain("t2", 3 + TAGS);

        // 3: ALU result with Tx_Ready held low for 5 cycles.
        Tx_Ready      = 1'b0;
        ALU_OUT       = 16'h1234;
        ALU_OUT_Valid = 1'b1;
        push_alu(16'h1234);
        tick();
        ALU_OUT_Valid = 1'b0;
        tick();
        for (int i = 0; i < 5; i++) begin
            check("t3_stall_valid", Tx_Valid, 1);
            check("t3_stall_data", Tx_P_Data, (TAGS != 0) ? 8'hA5 : 8'h34);
            tick();
        end
        Tx_Ready = 1'b1;
        drain("t3", 2 + TAGS);

        // 4: simultaneous strobes, read data first, no gaps.
        RdData        = 8'h55;
        RdData_Valid  = 1'b1;
        ALU_OUT       = 16'hBEEF;
        ALU_OUT_Valid = 1'b1;
        push_rd(8'h55);
        push_alu(16'hBEEF);
        tick();
        RdData_Valid  = 1'b0;
        ALU_OUT_Valid = 1'b0;
        drain("t4", 4 + 2 * TAGS);

        // 5: overrun on a second strobe; re-capture on the consuming cycle.
        ovr_cnt      = 0;
        Tx_Ready     = 1'b0;
        RdData       = 8'h55;
        RdData_Valid = 1'b1;
        push_rd(8'h55);
        tick();
        RdData_Valid = 1'b0;
        repeat (2) tick();
        RdData       = 8'h77;
        RdData_Valid = 1'b1;
        tick();
        RdData_Valid = 1'b0;
        tick();
        check("t5_overrun_count", ovr_cnt, 1);
        check("t5_held_data", Tx_P_Data, (TAGS != 0) ? 8'h5A : 8'h55);
        if (TAGS != 0) begin
            Tx_Ready = 1'b1;
            tick();
        end
        Tx_Ready     = 1'b1;
        RdData       = 8'h66;
        RdData_Valid = 1'b1;
        push_rd(8'h66);
        tick();
        RdData_Valid = 1'b0;
        drain("t5", 2 + TAGS);
        check("t5_no_extra_overrun", ovr_cnt, 1);

        // 6: reset in SEND_ALU_HI with a read pending discards everything.
        Tx_Ready      = 1'b1;
        ALU_OUT       = 16'hCAFE;
        ALU_OUT_Valid = 1'b1;
        if (TAGS != 0) exp_q.push_back(8'hA5);
        exp_q.push_back(8'hFE);
        tick();
        ALU_OUT_Valid = 1'b0;
        tick();
        RdData       = 8'h99;
        RdData_Valid = 1'b1;
        tick();
        RdData_Valid = 1'b0;
        if (TAGS != 0) tick();
        Tx_Ready = 1'b0;
        check("t6_hi_data", Tx_P_Data, 8'hCA);
        check("t6_busy_before", Busy, 1);
        Reset = 1'b1;
        tick();
        check("t6_valid", Tx_Valid, 0);
        check("t6_busy", Busy, 0);
        check("t6_data", Tx_P_Data, 0);
        Reset    = 1'b0;
        Tx_Ready = 1'b1;
        repeat (6) tick();
        check("t6_busy_after", Busy, 0);
        check("t6_queue_empty", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
